// File: rtl/demux_deserializer.sv
// Serial-to-parallel demux: steers single iData bits into four slot registers,
// either by an auto-incrementing counter or an explicit selector, and publishes full words.

module demux_slot_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic wr,
   input  logic din,
   input  logic flush,
   output logic q,
   output logic mask
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q    <= 1'b0;
         mask <= 1'b0;
      end else begin
         if (wr)
            q <= din;
         // flush wins over a write: the completing write itself leaves the mask empty
         if (flush)
            mask <= 1'b0;
         else if (wr)
            mask <= 1'b1;
      end
   end

endmodule

module demux_deserializer (
   input  logic       iClk,
   input  logic       iRst_n,
   input  logic       iData,
   input  logic       iValid,
   input  logic [1:0] iSelector,
   input  logic       iAuto,
   input  logic       iClear,
   output logic [3:0] oData,
   output logic [3:0] oWord,
   output logic       oWordValid,
   output logic [1:0] oSlot,
   output logic       oOverrun
);

   localparam int NUM_SLOTS = 4;

   typedef struct packed {
      logic       vld;
      logic [1:0] slot;
      logic       bit_val;
   } wr_req_t;

   wr_req_t              req;
   logic [NUM_SLOTS-1:0] mask;
   logic [NUM_SLOTS-1:0] hit;
   logic [NUM_SLOTS-1:0] mask_nxt;
   logic [NUM_SLOTS-1:0] data_nxt;
   logic                 done;
   logic                 rewrite;

   // A clear in the same cycle swallows the write entirely.
   always_comb begin
      req.vld     = iValid & ~iClear;
      req.slot    = iAuto ? oSlot : iSelector;
      req.bit_val = iData;
   end

   always_comb begin
      hit      = '0;
      data_nxt = oData;
      if (req.vld) begin
         hit[req.slot]      = 1'b1;
         data_nxt[req.slot] = req.bit_val;
      end
      mask_nxt = mask | hit;
      done     = req.vld & (&mask_nxt);
      rewrite  = |(mask & hit);
   end

   genvar g;
   generate
      for (g = 0; g < NUM_SLOTS; g++) begin : g_slot
         demux_slot_cell u_cell (
            .clk   (iClk),
            .rst_n (iRst_n),
            .wr    (hit[g]),
            .din   (req.bit_val),
            .flush (iClear | done),
            .q     (oData[g]),
            .mask  (mask[g])
         );
      end
   endgenerate

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         oWord      <= '0;
         oWordValid <= 1'b0;
         oSlot      <= '0;
         oOverrun   <= 1'b0;
      end else begin
         oWordValid <= done;
         if (done)
            oWord <= data_nxt;
         if (iClear) begin
            oSlot    <= '0;
            oOverrun <= 1'b0;
         end else begin
            if (req.vld && iAuto)
               oSlot <= oSlot + 2'd1;
            if (req.vld && rewrite)
               oOverrun <= 1'b1;
         end
      end
   end

endmodule
